// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI register responder.
package spi_pkg;

  localparam int   RW_BIT = 7;
  localparam logic CPOL   = 1'b0;
  localparam logic CPHA   = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer for an asynchronous pin, with rise/fall detection
// on the synchronized value.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  // [0],[1] form the synchronizer, [2] holds the previous synchronized value
  logic [2:0] r_sh;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh <= {3{RST_VAL}};
    end else begin
      r_sh <= {r_sh[1:0], i_d};
    end
  end

  assign o_sync = r_sh[1];
  assign o_rise = r_sh[1] & ~r_sh[2];
  assign o_fall = ~r_sh[1] & r_sh[2];

endmodule

// File: rtl/spi_reg_slave.sv
// Mode-0 SPI responder exposing a bank of 8-bit registers; the top address
// is a read-only status input.
import spi_pkg::*;

module spi_reg_slave #(
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              S_CLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              CS,
  input  logic [7:0]        STATUS_IN,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  output logic [7:0]        HOST_RDATA,
  output logic              WR_STROBE,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA,
  output logic              BUSY
);

  localparam int                NREG     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  state_e            r_state;
  state_e            w_next;
  logic [7:0]        r_regs [NREG];
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_rx_shift;
  logic [7:0]        r_tx_shift;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic              r_miso;
  logic              r_mosi_meta;
  logic              r_mosi_sync;
  logic              r_armed;
  logic              r_wr_strobe;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;

  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_cs_sync, w_cs_rise, w_cs_fall;

  spi_edge_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .i_clk  (CLK),
    .i_rst_n(CLR),
    .i_d    (S_CLK),
    .o_sync (w_sclk_sync),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // CS chain resets low so a frame already in progress at reset release
  // produces no falling edge and is ignored until CS next goes high.
  spi_edge_sync #(.RST_VAL(1'b0)) u_cs_sync (
    .i_clk  (CLK),
    .i_rst_n(CLR),
    .i_d    (CS),
    .o_sync (w_cs_sync),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  logic              w_sample;
  logic              w_shift;
  logic              w_active;
  logic [7:0]        w_rx_byte;
  logic              w_byte_done;
  logic [ADDR_W-1:0] w_next_addr;
  logic [ADDR_W-1:0] w_load_addr;
  logic [7:0]        w_load_val;
  logic              w_commit;

  assign w_sample    = (CPOL ^ CPHA) ? w_sclk_fall : w_sclk_rise;
  assign w_shift     = (CPOL ^ CPHA) ? w_sclk_rise : w_sclk_fall;
  assign w_active    = (r_state != IDLE);
  assign w_rx_byte   = {r_rx_shift[6:0], r_mosi_sync};
  assign w_byte_done = w_active & w_sample & (r_bit_cnt == 3'd7);
  assign w_next_addr = r_addr + ADDR_W'(1);
  assign w_load_addr = (r_state == CMD) ? w_rx_byte[ADDR_W-1:0] : w_next_addr;
  assign w_load_val  = (w_load_addr == TOP_ADDR) ? STATUS_IN : r_regs[w_load_addr];
  assign w_commit    = w_byte_done & (r_state == DATA) & ~r_rw & (r_addr != TOP_ADDR);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A byte finishing in the same cycle CS rises still commits, because the
  // datapath acts on w_byte_done before the state register drops to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_next = CMD;
      CMD:     if (w_cs_rise) w_next = IDLE;
               else if (w_byte_done) w_next = DATA;
      DATA:    if (w_cs_rise) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_addr      <= '0;
      r_rw        <= 1'b0;
      r_miso      <= 1'b0;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
      r_armed     <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_mosi_meta <= MOSI;
      r_mosi_sync <= r_mosi_meta;
      if (w_cs_sync) r_armed <= 1'b1;

      r_wr_strobe <= w_commit;
      if (w_commit) begin
        r_regs[r_addr] <= w_rx_byte;
        r_wr_addr      <= r_addr;
        r_wr_data      <= w_rx_byte;
      end

      if (r_state == IDLE) begin
        if (w_cs_fall) begin
          r_bit_cnt <= '0;
          r_miso    <= 1'b0;
        end
      end else if (w_sample) begin
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        r_rx_shift <= w_rx_byte;
        if (r_bit_cnt == 3'd7) begin
          // Read data is captured here, so later writes cannot alter it.
          r_addr     <= w_load_addr;
          r_tx_shift <= w_load_val;
          if (r_state == CMD) r_rw <= w_rx_byte[RW_BIT];
        end
      end else if (w_shift && r_state == DATA && r_rw) begin
        r_miso     <= r_tx_shift[7];
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
    end
  end

  assign MISO       = (!CS && w_active) ? r_miso : 1'bz;
  assign HOST_RDATA = (HOST_ADDR == TOP_ADDR) ? STATUS_IN : r_regs[HOST_ADDR];
  assign WR_STROBE  = r_wr_strobe;
  assign WR_ADDR    = r_wr_addr;
  assign WR_DATA    = r_wr_data;
  assign BUSY       = r_armed & ~w_cs_sync;

endmodule
